// File: rtl/fht_but_array_pkg.sv
// Shared types and constants for the FHT butterfly array.
// Permutation codes and the twiddle Q-format shift.
package fht_but_array_pkg;

    typedef enum logic [1:0] {
        PermNat      = 2'd0,
        PermSplit    = 2'd1,
        PermSplitRev = 2'd2,
        PermRsvd     = 2'd3
    } perm_e;

    // Twiddles are Q-format with 1.0 = 2^(W_BIT-2).
    function automatic int unsigned twid_shift(input int unsigned w_bit);
        return w_bit - 2;
    endfunction

endpackage

// File: rtl/fht_but_array_if.sv
// Beat interface of the FHT butterfly array: operands/twiddles/control in, lanes out.
interface fht_but_array_if #(
    parameter int unsigned D_BIT   = 17,
    parameter int unsigned W_BIT   = 12,
    parameter int unsigned NUM_BUT = 2
);
    logic                         iVALID;
    logic                         iSCALE;
    logic [1:0]                   iPERM;
    logic                         iCLR_OVF;
    logic [NUM_BUT*D_BIT-1:0]     iX_A;
    logic [NUM_BUT*D_BIT-1:0]     iX_B;
    logic [NUM_BUT*D_BIT-1:0]     iX_C;
    logic [NUM_BUT*W_BIT-1:0]     iCOS;
    logic [NUM_BUT*W_BIT-1:0]     iSIN;
    logic                         oVALID;
    logic [2*NUM_BUT*D_BIT-1:0]   oY;
    logic                         oOVF;

    modport master (
        output iVALID, iSCALE, iPERM, iCLR_OVF, iX_A, iX_B, iX_C, iCOS, iSIN,
        input  oVALID, oY, oOVF
    );

    modport slave (
        input  iVALID, iSCALE, iPERM, iCLR_OVF, iX_A, iX_B, iX_C, iCOS, iSIN,
        output oVALID, oY, oOVF
    );

endinterface

// File: rtl/fht_but_array_pipe.sv
// One radix-2 Hartley butterfly: S1 operand regs, S2 product regs, S3 combinational
// round/add/scale/saturate (the caller registers the result).
module fht_but_array_pipe
    import fht_but_array_pkg::*;
#(
    parameter int unsigned D_BIT = 17,
    parameter int unsigned W_BIT = 12
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic signed [D_BIT-1:0] i_a,
    input  logic signed [D_BIT-1:0] i_b,
    input  logic signed [D_BIT-1:0] i_c,
    input  logic signed [W_BIT-1:0] i_cos,
    input  logic signed [W_BIT-1:0] i_sin,
    input  logic                    i_scale,
    output logic signed [D_BIT-1:0] o_y0,
    output logic signed [D_BIT-1:0] o_y1,
    output logic                    o_sat
);

    localparam int unsigned SH = twid_shift(W_BIT);
    localparam int unsigned PW = D_BIT + W_BIT;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned TW = SW - SH;
    localparam int unsigned AW = TW + 1;
    localparam int unsigned HW = AW - D_BIT + 1;

    localparam logic signed [SW-1:0]    RND     = SW'(1) << (SH - 1);
    localparam logic signed [AW-1:0]    ONE     = AW'(1);
    localparam logic        [D_BIT-1:0] SAT_MAX = {1'b0, {(D_BIT-1){1'b1}}};
    localparam logic        [D_BIT-1:0] SAT_MIN = {1'b1, {(D_BIT-1){1'b0}}};

    logic signed [D_BIT-1:0] r_a, r_b, r_c, r_a2;
    logic signed [W_BIT-1:0] r_cos, r_sin;
    logic                    r_scale, r_scale2;
    logic signed [PW-1:0]    r_pb, r_pc;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_cos    <= '0;
            r_sin    <= '0;
            r_scale  <= 1'b0;
            r_a2     <= '0;
            r_pb     <= '0;
            r_pc     <= '0;
            r_scale2 <= 1'b0;
        end else begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_c      <= i_c;
            r_cos    <= i_cos;
            r_sin    <= i_sin;
            r_scale  <= i_scale;
            r_a2     <= r_a;
            r_pb     <= PW'(r_b) * PW'(r_cos);
            r_pc     <= PW'(r_c) * PW'(r_sin);
            r_scale2 <= r_scale;
        end
    end

    logic signed [SW-1:0] w_p, w_pr;
    logic signed [TW-1:0] w_t;
    logic signed [AW-1:0] w_a, w_te, w_s0, w_s1, w_s0i, w_s1i, w_s0s, w_s1s;
    logic                 w_ovf0, w_ovf1;

    always_comb begin
        w_p   = SW'(r_pb) + SW'(r_pc);
        w_pr  = w_p + RND;
        w_t   = TW'(w_pr >>> SH);
        w_a   = AW'(r_a2);
        w_te  = AW'(w_t);
        w_s0  = w_a + w_te;
        w_s1  = w_a - w_te;
        w_s0i = w_s0 + ONE;
        w_s1i = w_s1 + ONE;
        w_s0s = r_scale2 ? (w_s0i >>> 1) : w_s0;
        w_s1s = r_scale2 ? (w_s1i >>> 1) : w_s1;
        // Out of range when the bits above the result sign are not a pure sign extension.
        w_ovf0 = (w_s0s[AW-1:D_BIT-1] != {HW{w_s0s[AW-1]}});
        w_ovf1 = (w_s1s[AW-1:D_BIT-1] != {HW{w_s1s[AW-1]}});
        o_y0   = w_ovf0 ? (w_s0s[AW-1] ? SAT_MIN : SAT_MAX) : w_s0s[D_BIT-1:0];
        o_y1   = w_ovf1 ? (w_s1s[AW-1] ? SAT_MIN : SAT_MAX) : w_s1s[D_BIT-1:0];
        o_sat  = w_ovf0 | w_ovf1;
    end

endmodule

// File: rtl/fht_but_array.sv
// Array of NUM_BUT pipelined Hartley butterflies with valid/permutation delay line,
// output lane permutation, output registers and sticky saturation flag.
module fht_but_array
    import fht_but_array_pkg::*;
#(
    parameter int unsigned D_BIT   = 17,
    parameter int unsigned W_BIT   = 12,
    parameter int unsigned NUM_BUT = 2
) (
    input logic            iCLK,
    input logic            iRESET,
    fht_but_array_if.slave bus
);

    localparam int unsigned LANES = 2 * NUM_BUT;

    logic signed [D_BIT-1:0] w_y0 [NUM_BUT];
    logic signed [D_BIT-1:0] w_y1 [NUM_BUT];
    logic [NUM_BUT-1:0]      w_sat;

    for (genvar k = 0; k < NUM_BUT; k++) begin : g_but
        fht_but_array_pipe #(
            .D_BIT (D_BIT),
            .W_BIT (W_BIT)
        ) u_but (
            .iCLK    (iCLK),
            .iRESET  (iRESET),
            .i_a     (bus.iX_A[k*D_BIT +: D_BIT]),
            .i_b     (bus.iX_B[k*D_BIT +: D_BIT]),
            .i_c     (bus.iX_C[k*D_BIT +: D_BIT]),
            .i_cos   (bus.iCOS[k*W_BIT +: W_BIT]),
            .i_sin   (bus.iSIN[k*W_BIT +: W_BIT]),
            .i_scale (bus.iSCALE),
            .o_y0    (w_y0[k]),
            .o_y1    (w_y1[k]),
            .o_sat   (w_sat[k])
        );
    end

    logic                     r_vld1, r_vld2, r_ovalid, r_ovf;
    perm_e                    r_perm1, r_perm2;
    logic [LANES*D_BIT-1:0]   r_y, w_y;
    logic                     w_ovf;

    always_comb begin
        w_y = '0;
        for (int k = 0; k < NUM_BUT; k++) begin
            case (r_perm2)
                PermSplit: begin
                    w_y[k*D_BIT +: D_BIT]           = w_y0[k];
                    w_y[(NUM_BUT+k)*D_BIT +: D_BIT] = w_y1[k];
                end
                PermSplitRev: begin
                    w_y[k*D_BIT +: D_BIT]           = w_y0[NUM_BUT-1-k];
                    w_y[(NUM_BUT+k)*D_BIT +: D_BIT] = w_y1[NUM_BUT-1-k];
                end
                default: begin
                    w_y[(2*k)*D_BIT +: D_BIT]   = w_y0[k];
                    w_y[(2*k+1)*D_BIT +: D_BIT] = w_y1[k];
                end
            endcase
        end
    end

    // A saturating valid beat in S3 wins over a simultaneous clear.
    always_comb begin
        w_ovf = (r_vld2 && (|w_sat)) || (r_ovf && !bus.iCLR_OVF);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_vld1   <= 1'b0;
            r_vld2   <= 1'b0;
            r_perm1  <= PermNat;
            r_perm2  <= PermNat;
            r_ovalid <= 1'b0;
            r_y      <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_vld1   <= bus.iVALID;
            r_perm1  <= perm_e'(bus.iPERM);
            r_vld2   <= r_vld1;
            r_perm2  <= r_perm1;
            r_ovalid <= r_vld2;
            r_y      <= w_y;
            r_ovf    <= w_ovf;
        end
    end

    assign bus.oVALID = r_ovalid;
    assign bus.oY     = r_y;
    assign bus.oOVF   = r_ovf;

endmodule

// File: tb/tb_fht_but_array.sv
// Bench for fht_but_array: directed vector table, ovf/clear and reset sequences,
// and random beats against an arithmetic reference model.
module tb_fht_but_array;

    localparam int D  = 17;
    localparam int W  = 12;
    localparam int NB = 2;
    localparam int NL = 4;

    logic iCLK   = 1'b0;
    logic iRESET = 1'b0;
    always #5 iCLK = ~iCLK;

    fht_but_array_if #(.D_BIT(D), .W_BIT(W), .NUM_BUT(NB)) bus ();

    fht_but_array #(.D_BIT(D), .W_BIT(W), .NUM_BUT(NB)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    typedef struct {
        logic       vld;
        logic       scale;
        logic [1:0] perm;
        logic       clr;
        int         a  [NB];
        int         b  [NB];
        int         c  [NB];
        int         cs [NB];
        int         sn [NB];
    } beat_t;

    typedef struct {
        logic vld;
        int   lanes [NL];
        logic sat;
    } exp_t;

    typedef struct {
        beat_t in;
        int    lanes [NL];
        logic  sat;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    exp_t  q[$];
    logic  ovf_m;
    logic  last_clr;
    vec_t  tbl [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int clamp(input longint v, output logic s);
        s = 1'b0;
        if (v > 65535)       begin s = 1'b1; return 65535;  end
        else if (v < -65536) begin s = 1'b1; return -65536; end
        return int'(v);
    endfunction

    function automatic exp_t model(input beat_t bt);
        exp_t   e;
        longint p, t, s0, s1;
        int     y0 [NB];
        int     y1 [NB];
        logic   f0, f1;
        e.vld = bt.vld;
        e.sat = 1'b0;
        for (int k = 0; k < NB; k++) begin
            p  = longint'(bt.b[k]) * bt.cs[k] + longint'(bt.c[k]) * bt.sn[k];
            t  = (p + 512) >>> 10;
            s0 = bt.a[k] + t;
            s1 = bt.a[k] - t;
            if (bt.scale) begin
                s0 = (s0 + 1) >>> 1;
                s1 = (s1 + 1) >>> 1;
            end
            y0[k] = clamp(s0, f0);
            y1[k] = clamp(s1, f1);
            e.sat = e.sat | f0 | f1;
        end
        for (int k = 0; k < NB; k++) begin
            if (bt.perm == 2'd1) begin
                e.lanes[k] = y0[k];       e.lanes[NB+k] = y1[k];
            end else if (bt.perm == 2'd2) begin
                e.lanes[k] = y0[NB-1-k];  e.lanes[NB+k] = y1[NB-1-k];
            end else begin
                e.lanes[2*k] = y0[k];     e.lanes[2*k+1] = y1[k];
            end
        end
        return e;
    endfunction

    function automatic beat_t idle(input logic clr);
        beat_t b;
        b.vld = 1'b0; b.scale = 1'b0; b.perm = 2'd0; b.clr = clr;
        for (int k = 0; k < NB; k++) begin
            b.a[k] = 0; b.b[k] = 0; b.c[k] = 0; b.cs[k] = 0; b.sn[k] = 0;
        end
        return b;
    endfunction

    function automatic beat_t mk(input int a0, input int b0, input int c0, input int cs0,
                                 input int sn0, input int a1, input int b1, input int c1,
                                 input int cs1, input int sn1, input logic sc,
                                 input logic [1:0] pm);
        beat_t b;
        b = idle(1'b0);
        b.vld = 1'b1; b.scale = sc; b.perm = pm;
        b.a[0] = a0; b.b[0] = b0; b.c[0] = c0; b.cs[0] = cs0; b.sn[0] = sn0;
        b.a[1] = a1; b.b[1] = b1; b.c[1] = c1; b.cs[1] = cs1; b.sn[1] = sn1;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b = idle($urandom_range(0, 15) == 0);
        b.vld   = ($urandom_range(0, 3) != 0);
        b.scale = $urandom_range(0, 1);
        b.perm  = 2'($urandom_range(0, 3));
        for (int k = 0; k < NB; k++) begin
            b.a[k]  = int'($urandom_range(0, 131071)) - 65536;
            b.b[k]  = int'($urandom_range(0, 131071)) - 65536;
            b.c[k]  = int'($urandom_range(0, 131071)) - 65536;
            b.cs[k] = int'($urandom_range(0, 2048)) - 1024;
            b.sn[k] = int'($urandom_range(0, 2048)) - 1024;
        end
        return b;
    endfunction

    task automatic drive(input beat_t bt);
        bus.iVALID   = bt.vld;
        bus.iSCALE   = bt.scale;
        bus.iPERM    = bt.perm;
        bus.iCLR_OVF = bt.clr;
        for (int k = 0; k < NB; k++) begin
            bus.iX_A[k*D +: D] = D'(bt.a[k]);
            bus.iX_B[k*D +: D] = D'(bt.b[k]);
            bus.iX_C[k*D +: D] = D'(bt.c[k]);
            bus.iCOS[k*W +: W] = W'(bt.cs[k]);
            bus.iSIN[k*W +: W] = W'(bt.sn[k]);
        end
    endtask

    task automatic sb_init();
        exp_t e;
        e.vld = 1'b0; e.sat = 1'b0;
        for (int j = 0; j < NL; j++) e.lanes[j] = 0;
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(e);
        ovf_m    = 1'b0;
        last_clr = 1'b0;
    endtask

    // One clock: check the beat issued three cycles ago, then issue the next one.
    task automatic cycle(input beat_t bt, input exp_t ex);
        exp_t e;
        @(posedge iCLK);
        #1;
        e = q.pop_front();
        ovf_m = (e.vld && e.sat) || (ovf_m && !last_clr);
        check("oVALID", int'(bus.oVALID), int'(e.vld));
        check("oOVF", int'(bus.oOVF), int'(ovf_m));
        if (e.vld) begin
            for (int j = 0; j < NL; j++)
                check($sformatf("lane%0d", j), int'($signed(bus.oY[j*D +: D])), e.lanes[j]);
        end
        drive(bt);
        last_clr = bt.clr;
        q.push_back(ex);
    endtask

    task automatic cyc_model(input beat_t bt);
        cycle(bt, model(bt));
    endtask

    initial begin
        exp_t  e;
        beat_t b;

        tbl[0].in = mk(100, 50, 7, 1024, 0,  0, 0, 0, 1024, 0,  1'b0, 2'd0);
        tbl[0].lanes = '{150, 50, 0, 0};      tbl[0].sat = 1'b0;
        tbl[1].in = mk(0, 3, 0, 512, 0,  0, 0, 0, 1024, 0,  1'b0, 2'd0);
        tbl[1].lanes = '{2, -2, 0, 0};        tbl[1].sat = 1'b0;
        tbl[2].in = mk(0, 3, -5, 0, 1024,  0, 0, 0, 1024, 0,  1'b0, 2'd0);
        tbl[2].lanes = '{-5, 5, 0, 0};        tbl[2].sat = 1'b0;
        tbl[3].in = mk(65535, 65535, 0, 1024, 0,  0, 0, 0, 1024, 0,  1'b0, 2'd0);
        tbl[3].lanes = '{65535, 0, 0, 0};     tbl[3].sat = 1'b1;
        tbl[4].in = mk(65535, 65535, 0, 1024, 0,  0, 0, 0, 1024, 0,  1'b1, 2'd0);
        tbl[4].lanes = '{65535, 0, 0, 0};     tbl[4].sat = 1'b0;
        for (int p = 0; p < 4; p++) begin
            tbl[5+p].in  = mk(2, -1, 0, 1024, 0,  6, -1, 0, 1024, 0,  1'b1, 2'(p));
            tbl[5+p].sat = 1'b0;
        end
        tbl[5].lanes = '{1, 2, 3, 4};
        tbl[6].lanes = '{1, 3, 2, 4};
        tbl[7].lanes = '{3, 1, 4, 2};
        tbl[8].lanes = '{1, 2, 3, 4};

        drive(idle(1'b0));
        #1;
        check("rst_oVALID", int'(bus.oVALID), 0);
        check("rst_oY", int'(bus.oY != '0), 0);
        check("rst_oOVF", int'(bus.oOVF), 0);
        #11 iRESET = 1'b1;
        sb_init();

        // Directed vectors back to back, alternating permutation at the end.
        for (int i = 0; i < 9; i++) begin
            e.vld = 1'b1;
            e.sat = tbl[i].sat;
            e.lanes = tbl[i].lanes;
            cycle(tbl[i].in, e);
        end
        for (int i = 0; i < 3; i++) cyc_model(idle(1'b0));
        check("ovf_sticky", int'(bus.oOVF), 1);

        // Clear alone, then a clear coinciding with a saturating beat in S3.
        cyc_model(idle(1'b1));
        cyc_model(idle(1'b0));
        check("ovf_cleared", int'(bus.oOVF), 0);
        cycle(tbl[3].in, '{vld: 1'b1, lanes: tbl[3].lanes, sat: 1'b1});
        cyc_model(idle(1'b0));
        cyc_model(idle(1'b1));
        cyc_model(idle(1'b1));
        check("ovf_set_wins", int'(bus.oOVF), 1);
        cyc_model(idle(1'b0));
        check("ovf_clear_again", int'(bus.oOVF), 0);

        for (int i = 0; i < 300; i++) cyc_model(rnd_beat());
        for (int i = 0; i < 3; i++) cyc_model(idle(1'b0));

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) cyc_model(tbl[5+i].in);
        #2;
        iRESET = 1'b0;
        bus.iVALID = 1'b0;
        #1;
        check("midrst_oVALID", int'(bus.oVALID), 0);
        check("midrst_oY", int'(bus.oY != '0), 0);
        check("midrst_oOVF", int'(bus.oOVF), 0);
        #10 iRESET = 1'b1;
        sb_init();
        for (int i = 0; i < 5; i++) cyc_model(idle(1'b0));
        b = tbl[0].in;
        cyc_model(b);
        for (int i = 0; i < 3; i++) cyc_model(idle(1'b0));
        check("post_rst_valid", int'(bus.oVALID), 1);
        check("post_rst_lane0", int'($signed(bus.oY[0 +: D])), 150);
        cyc_model(idle(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
